// File: rtl/booth_shreg_pkg.sv
// Shared encodings for the Booth multiplier shift register: shift modes and controller states.
package booth_shreg_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/booth_shreg_step.sv
// Combinational single-step shifter: one right (dir=0) or left (dir=1) step plus the bit shifted out.
module booth_shreg_step
  import booth_shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             fill,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             so
);

  always_comb begin
    q  = d;
    so = 1'b0;
    if (dir) begin
      so = d[WIDTH-1];
      // Arithmetic left is identical to logical left.
      case (mode)
        MODE_ROT: q = {d[WIDTH-2:0], d[WIDTH-1]};
        default:  q = {d[WIDTH-2:0], fill};
      endcase
    end else begin
      so = d[0];
      // Mode 11 falls through to logical.
      case (mode)
        MODE_ARI: q = {d[WIDTH-1], d[WIDTH-1:1]};
        MODE_ROT: q = {d[0], d[WIDTH-1:1]};
        default:  q = {fill, d[WIDTH-1:1]};
      endcase
    end
  end

endmodule

// File: rtl/booth_shreg.sv
// Booth datapath shift register: load, single step, counted run with busy/done handshake.
// Define BOOTH_SHREG_LEFT_EN to add the dir port and left shifts; otherwise all shifts go right.
module booth_shreg
  import booth_shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sft,
  input  logic             start,
  input  logic [CNT_W-1:0] n_sft,
  input  logic [1:0]       mode,
  input  logic             SR_in,
`ifdef BOOTH_SHREG_LEFT_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             SO,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_start;
  logic [WIDTH-1:0] step_q;
  logic             step_so;
  logic             step_dir;

`ifdef BOOTH_SHREG_LEFT_EN
  assign step_dir = dir;
`else
  assign step_dir = 1'b0;
`endif

  assign cnt_start = (n_sft > MAX_CNT) ? MAX_CNT : n_sft;

  booth_shreg_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .d   (data_out),
    .mode(mode),
    .fill(SR_in),
    .dir (step_dir),
    .q   (step_q),
    .so  (step_so)
  );

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      data_out <= '0;
      SO       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld) begin
            data_out <= data_in;
            SO       <= 1'b0;
          end else if (start) begin
            cnt <= cnt_start;
            // A zero-length run completes on the spot without entering RUN.
            if (cnt_start == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end else if (sft) begin
            data_out <= step_q;
            SO       <= step_so;
          end
        end
        RUN: begin
          data_out <= step_q;
          SO       <= step_so;
          cnt      <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_shreg.sv
// Scoreboard bench for booth_shreg: stimulus pushes expected results, a monitor pops on done/step.
module tb_booth_shreg;
  import booth_shreg_pkg::*;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          ld = 1'b0, sft = 1'b0, start = 1'b0, SR_in = 1'b0, dir = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [CW-1:0] n_sft = '0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  data_out;
  logic          SO, busy, done;

  booth_shreg #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .ld      (ld),
    .data_in (data_in),
    .sft     (sft),
    .start   (start),
    .n_sft   (n_sft),
    .mode    (mode),
    .SR_in   (SR_in),
`ifdef BOOTH_SHREG_LEFT_EN
    .dir     (dir),
`endif
    .data_out(data_out),
    .SO      (SO),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           run;
    logic [W-1:0] data;
    logic         so;
    int           nbusy;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           step_chk = 0;
  logic [W-1:0] model_d = '0;
  logic         model_so = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural step: plain shift/rotate arithmetic on the whole word.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] d, input logic [1:0] m,
                                            input logic f, input logic left, output logic so);
    logic [W-1:0] r;
    if (left) begin
      so = d[W-1];
      if (m == MODE_ROT) r = (d << 1) | (d >> (W - 1));
      else               r = (d << 1) | W'(f);
    end else begin
      so = d[0];
      if (m == MODE_ARI)      r = W'($signed(d) >>> 1);
      else if (m == MODE_ROT) r = (d >> 1) | (d << (W - 1));
      else                    r = (d >> 1) | (W'(f) << (W - 1));
    end
    return r;
  endfunction

  // Monitor: compares on every done pulse and on every flagged single-edge operation.
  int  busy_cnt = 0;
  bit  prev_done = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (clr) begin
        busy_cnt  = 0;
        prev_done = 0;
      end else begin
        if (done) begin
          chk("done_width", {31'd0, prev_done}, 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_kind", {31'd0, e.run}, 32'd1);
            chk("run_data", 32'(data_out), 32'(e.data));
            chk("run_so", {31'd0, SO}, {31'd0, e.so});
            chk("busy_edges", busy_cnt, e.nbusy);
          end
          busy_cnt = 0;
        end else if (step_chk) begin
          step_chk = 0;
          if (exp_q.size() == 0) begin
            chk("missing_expect", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("step_kind", {31'd0, e.run}, 32'd0);
            chk("step_data", 32'(data_out), 32'(e.data));
            chk("step_so", {31'd0, SO}, {31'd0, e.so});
            chk("step_busy", {31'd0, busy}, 32'd0);
          end
        end
        if (busy) busy_cnt++;
        prev_done = done;
      end
    end
  end

  task automatic do_ld(input logic [W-1:0] v);
    @(posedge clk);
    ld = 1'b1;
    data_in = v;
    model_d = v;
    model_so = 1'b0;
    exp_q.push_back('{run: 0, data: v, so: 1'b0, nbusy: 0});
    @(negedge clk);
    #1 ld = 1'b0;
    step_chk = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_sft(input logic [1:0] m, input logic f, input logic dr);
    @(posedge clk);
    mode = m;
    SR_in = f;
    dir = dr;
    sft = 1'b1;
    model_d = ref_step(model_d, m, f, dr, model_so);
    exp_q.push_back('{run: 0, data: model_d, so: model_so, nbusy: 0});
    @(negedge clk);
    #1 sft = 1'b0;
    step_chk = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input logic [1:0] m, input logic f, input logic dr, input int n,
                        input bit noise);
    int nc;
    bit finished;
    nc = (n > W) ? W : n;
    @(posedge clk);
    mode = m;
    SR_in = f;
    dir = dr;
    start = 1'b1;
    n_sft = CW'(n);
    for (int i = 0; i < nc; i++) model_d = ref_step(model_d, m, f, dr, model_so);
    exp_q.push_back('{run: 1, data: model_d, so: model_so, nbusy: nc});
    @(negedge clk);
    #1 start = 1'b0;
    if (noise && nc > 0) begin
      // Requests during a run must be ignored.
      @(posedge clk);
      ld = 1'b1;
      sft = 1'b1;
      start = 1'b1;
      data_in = W'($urandom);
      @(posedge clk);
      ld = 1'b0;
      sft = 1'b0;
      start = 1'b0;
    end
    finished = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      chk("run_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #1;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_so", {31'd0, SO}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    do_ld(16'h8003);
    do_run(MODE_ARI, 1'b0, 1'b0, 4, 0);
    chk("ari_run_data", 32'(data_out), 32'h0000F800);

    do_ld(16'h0001);
    do_sft(MODE_LOG, 1'b1, 1'b0);
    chk("log_sft_data", 32'(data_out), 32'h00008000);
    chk("log_sft_so", {31'd0, SO}, 32'd1);

    do_ld(16'h1234);
    do_run(MODE_ROT, 1'b0, 1'b0, 20, 0);
    chk("rot_clamp_data", 32'(data_out), 32'h00001234);

    // Clear in the middle of an 8-step run.
    do_ld(16'hBEEF);
    @(posedge clk);
    mode = MODE_ROT;
    start = 1'b1;
    n_sft = CW'(8);
    @(negedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    #1 clr = 1'b1;
    #1;
    chk("clr_data", 32'(data_out), 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_so", {31'd0, SO}, 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    model_d = '0;
    model_so = 1'b0;
    repeat (4) @(posedge clk);
    do_ld(16'hA5C3);
    do_run(MODE_LOG, 1'b1, 1'b0, 5, 0);

    // Zero-length run.
    do_run(MODE_LOG, 1'b1, 1'b0, 0, 0);
    chk("n0_data", 32'(data_out), 32'h0000A5C3 >> 5 | 32'h0000F800);

    // Load beats start in the same edge.
    @(posedge clk);
    ld = 1'b1;
    start = 1'b1;
    n_sft = CW'(5);
    data_in = 16'h0F0F;
    model_d = 16'h0F0F;
    model_so = 1'b0;
    exp_q.push_back('{run: 0, data: 16'h0F0F, so: 1'b0, nbusy: 0});
    @(negedge clk);
    #1 ld = 1'b0;
    start = 1'b0;
    step_chk = 1;
    repeat (3) @(posedge clk);
    #1 chk("ld_start_busy", {31'd0, busy}, 32'd0);

`ifdef BOOTH_SHREG_LEFT_EN
    do_ld(16'h4001);
    do_run(MODE_LOG, 1'b0, 1'b1, 2, 0);
    chk("left_data", 32'(data_out), 32'h00000004);
    chk("left_so", {31'd0, SO}, 32'd1);
`endif

    for (int k = 0; k < 60; k++) begin
      logic [1:0] m;
      logic       f;
      logic       dr;
      m = 2'($urandom_range(0, 3));
      f = 1'($urandom);
`ifdef BOOTH_SHREG_LEFT_EN
      dr = 1'($urandom);
`else
      dr = 1'b0;
`endif
      case ($urandom_range(0, 2))
        0:       do_ld(W'($urandom));
        1:       do_sft(m, f, dr);
        default: do_run(m, f, dr, int'($urandom_range(0, (1 << CW) - 1)), 1'($urandom));
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_shreg.md
# booth_shreg

Parametrised shift register for the Booth multiplier datapath: parallel load, single-step shift, and a counted multi-step shift run with a busy/done handshake. Supports logical, arithmetic and rotate modes and reports the last bit shifted out. Sits beside the multiplier controller, which loads an operand, issues `start` with a shift count and waits for `done`.

## Interface
- `WIDTH`, 16: register width in bits, at least 2.
- `CNT_W`, $clog2(WIDTH+1): width of the shift-count input, derived.
- `clk`  in  1: single clock. All state updates on the falling edge.
- `clr`  in  1: asynchronous, active-high reset.
- `ld`  in  1: parallel load request.
- `data_in`  in  WIDTH: parallel load value.
- `sft`  in  1: single-step shift request in IDLE.
- `start`  in  1: begin a counted shift run in IDLE.
- `n_sft`  in  CNT_W: shift count, sampled with `start`.
- `mode`  in  2: 00 logical (fill from `SR_in`), 01 arithmetic (fill with MSB), 10 rotate, 11 treated as 00.
- `SR_in`  in  1: serial fill bit for logical mode.
- `dir`  in  1: 0 right, 1 left. Present only with `BOOTH_SHREG_LEFT_EN`.
- `data_out`  out  WIDTH: register contents.
- `SO`  out  1: bit shifted out by the most recent shift.
- `busy`  out  1: a run is in progress.
- `done`  out  1: one-cycle pulse at the end of a run.

## Operation
- States: IDLE and RUN. Reset state is IDLE.
- Reset values: `data_out`=0, `SO`=0, `busy`=0, `done`=0, count=0.
- IDLE priority, per edge: `ld` > `start` > `sft`. Exactly one action is taken.
  - `ld` loads `data_in` and sets `SO`=0.
  - `start` latches min(`n_sft`, WIDTH) into the counter. If the latched count is 0, go nowhere: `done`=1 for one cycle, `busy` stays 0, data is unchanged. Otherwise go to RUN with `busy`=1.
  - `sft` performs one shift step using the current `mode`.
- RUN: one shift step per edge and the counter decrements. The step that brings the counter to 0 returns to IDLE with `busy`=0 and `done`=1.
- In RUN, `ld`, `start` and `sft` are ignored. `mode`, `SR_in` and `dir` are sampled every step; the controller holds them stable for the whole run.
- `done` is cleared on the next edge.
- Right step:
  - logical: `{SR_in, d[W-1:1]}`
  - arithmetic: `{d[W-1], d[W-1:1]}`
  - rotate: `{d[0], d[W-1:1]}`
  - `SO` = `d[0]`
- Asserting `clr` mid-run clears state immediately. No `done` is produced.

## Timing
- `start` sampled at edge E0 with n>0: shifts occur at E1..En; `busy` is high from after E0 to after En; `done` is high from En to En+1.
- A run of n shifts costs n+1 edges start-to-done. A new `start` is accepted on the edge after `done` rises.
- `ld` and `sft` have one-edge latency.
- Outputs are registered; none is combinational from inputs.

## Configuration
- `BOOTH_SHREG_LEFT_EN` defined: the `dir` port exists.
  - dir=1 left step, logical: `{d[W-2:0], SR_in}`
  - arithmetic: same as logical
  - rotate: `{d[W-2:0], d[W-1]}`
  - `SO` = `d[W-1]`
- Undefined: no `dir` port; all shifts are right shifts.

## Structure
- Package `booth_shreg_pkg`: mode encodings (MODE_LOG, MODE_ARI, MODE_ROT) and the state enum (IDLE, RUN).
- Sub-module `booth_shreg_step`: combinational single-step shifter taking data, mode, fill bit and dir, returning next data and the shifted-out bit. Used by both the `sft` path and the RUN path.

## Test plan
- `ld` 0x8003, `start` n=4, arithmetic → `data_out`=0xF800, `SO`=0, `busy` high 4 edges, `done` pulse 1 cycle after E4.
- `ld` 0x0001, `sft` logical with `SR_in`=1 → `data_out`=0x8000, `SO`=1.
- `ld` 0x1234, `start` n=20, rotate → clamped to 16 shifts, `data_out`=0x1234, `done` after E16.
- `start` n=8 and `clr` asserted between falling edges after 6 shifts → immediately `data_out`=0, `busy`=0, no `done`; a following `start` runs normally.
- `start` n=0 → `done` pulse after E0, `busy` never high, data unchanged. `ld` and `start` together in IDLE → load wins, no run.
- With `BOOTH_SHREG_LEFT_EN`: `ld` 0x4001, dir=1, logical, `SR_in`=0, n=2 → `data_out`=0x0004, `SO`=1.
